// File: rtl/my_countdown_timer_pkg.sv
// Shared types, BCD constants and helpers for the mm:ss countdown timer.
package my_countdown_timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit, input logic [3:0] limit);
        return (digit > limit) ? limit : digit;
    endfunction

    function automatic int unsigned bcd_value(input logic [7:0] b);
        return 32'(b[7:4]) * 32'd10 + 32'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int unsigned v);
        return {4'(v / 32'd10), 4'(v % 32'd10)};
    endfunction

endpackage

// File: rtl/my_countdown_timer_if.sv
// Control/data bundle between the timer and its controller (load, run control, digits, flags).
interface my_countdown_timer_if;

    logic       tick;
    logic       ld;
    logic [7:0] d_min;
    logic [7:0] d_sec;
    logic       start;
    logic       pause;
    logic [7:0] q_min;
    logic [7:0] q_sec;
    logic       run;
    logic       done;
    logic       alm;
    logic       zero;

    modport master (
        output tick, ld, d_min, d_sec, start, pause,
        input  q_min, q_sec, run, done, alm, zero
    );

    modport slave (
        input  tick, ld, d_min, d_sec, start, pause,
        output q_min, q_sec, run, done, alm, zero
    );

endinterface

// File: rtl/my_countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit with synchronous load; wraps 0 -> MODULUS_TOP and borrows out.
module my_countdown_timer_bcd_down_digit #(
    parameter logic [3:0] MODULUS_TOP = 4'd9
) (
    input  logic       cp,
    input  logic       cr,
    input  logic       ld,
    input  logic [3:0] d,
    input  logic       en,
    output logic [3:0] q,
    output logic       bo
);

    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = (q_q == 4'd0) ? MODULUS_TOP : q_q - 4'd1;
        end
    end

    always_ff @(posedge cp) begin
        if (!cr) begin
            q_q <= 4'd0;
        end else if (!ld) begin
            q_q <= d;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign bo = en && (q_q == 4'd0);

endmodule

// File: rtl/my_countdown_timer.sv
// mm:ss BCD countdown timer: preload, run/pause on pulses, decrement per 1 Hz tick,
// flag DONE at 00:00 and hold the alarm for ALARM_TICKS ticks.
module my_countdown_timer
    import my_countdown_timer_pkg::*;
#(
    parameter int unsigned MAX_MIN     = 99,
    parameter int unsigned ALARM_TICKS = 10
) (
    input logic                 cp,
    input logic                 cr,
    my_countdown_timer_if.slave bus
);

    localparam int unsigned    CntW      = $clog2(ALARM_TICKS + 1);
    localparam logic [7:0]     MaxMinBcd = to_bcd(MAX_MIN);

    state_e            state_q, state_d;
    logic              alm_q, alm_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [3:0] q_su, q_st, q_mu, q_mt;
    logic       bo_su, bo_st, bo_mu, unused_bo_mt;
    logic [3:0] ld_su, ld_st;
    logic [7:0] ld_min;
    logic       zero, at_one, dec_en;

    assign ld_su = bcd_clamp(bus.d_sec[3:0], BCD_NINE);
    assign ld_st = bcd_clamp(bus.d_sec[7:4], BCD_FIVE);

    // Digits are clamped first, then the whole minute value is limited.
    always_comb begin
        ld_min = {bcd_clamp(bus.d_min[7:4], BCD_NINE), bcd_clamp(bus.d_min[3:0], BCD_NINE)};
        if (bcd_value(ld_min) > MAX_MIN) begin
            ld_min = MaxMinBcd;
        end
    end

    assign zero   = ({q_mt, q_mu, q_st, q_su} == 16'h0000);
    assign at_one = ({q_mt, q_mu, q_st, q_su} == 16'h0001);
    // A PAUSE in RUN is a transition, so it suppresses a coincident decrement.
    assign dec_en = (state_q == StRun) && bus.tick && !bus.pause && !zero;

    my_countdown_timer_bcd_down_digit #(.MODULUS_TOP(BCD_NINE)) u_sec_units (
        .cp(cp), .cr(cr), .ld(bus.ld), .d(ld_su), .en(dec_en), .q(q_su), .bo(bo_su)
    );
    my_countdown_timer_bcd_down_digit #(.MODULUS_TOP(BCD_FIVE)) u_sec_tens (
        .cp(cp), .cr(cr), .ld(bus.ld), .d(ld_st), .en(bo_su), .q(q_st), .bo(bo_st)
    );
    my_countdown_timer_bcd_down_digit #(.MODULUS_TOP(BCD_NINE)) u_min_units (
        .cp(cp), .cr(cr), .ld(bus.ld), .d(ld_min[3:0]), .en(bo_st), .q(q_mu), .bo(bo_mu)
    );
    my_countdown_timer_bcd_down_digit #(.MODULUS_TOP(BCD_NINE)) u_min_tens (
        .cp(cp), .cr(cr), .ld(bus.ld), .d(ld_min[7:4]), .en(bo_mu), .q(q_mt),
        .bo(unused_bo_mt)
    );

    always_comb begin
        state_d = state_q;
        alm_d   = alm_q;
        cnt_d   = cnt_q;
        if (!bus.ld) begin
            state_d = StIdle;
            alm_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start && !bus.pause && !zero) state_d = StRun;
                end
                StRun: begin
                    if (bus.pause) begin
                        state_d = StPause;
                    end else if (dec_en && at_one) begin
                        state_d = StDone;
                        alm_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
                StPause: begin
                    if (bus.start && !bus.pause) state_d = StRun;
                end
                StDone: begin
                    if (bus.tick && alm_q) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CntW'(ALARM_TICKS - 1)) alm_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge cp) begin
        if (!cr) begin
            state_q <= StIdle;
            alm_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            alm_q   <= alm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.q_min = {q_mt, q_mu};
    assign bus.q_sec = {q_st, q_su};
    assign bus.run   = (state_q == StRun);
    assign bus.done  = (state_q == StDone);
    assign bus.alm   = alm_q;
    assign bus.zero  = zero;

endmodule

// File: tb/tb_my_countdown_timer.sv
// Bench for my_countdown_timer: two instances (MAX_MIN 99 and 30) against a seconds-count model.
module tb_my_countdown_timer;

    localparam int MIdle = 0, MRun = 1, MPause = 2, MDone = 3;
    localparam int AlarmTicks = 10;

    logic       cp = 1'b0;
    logic       cr, tick, ld, start, pause;
    logic [7:0] d_min, d_sec;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining time as a plain seconds count per instance.
    int max_min [2] = '{99, 30};
    int total   [2] = '{0, 0};
    int mode    [2] = '{MIdle, MIdle};
    bit m_alm   [2] = '{1'b0, 1'b0};
    int alm_left[2] = '{0, 0};

    logic [7:0] o_min [2];
    logic [7:0] o_sec [2];
    logic       o_run [2];
    logic       o_done[2];
    logic       o_alm [2];
    logic       o_zero[2];

    always #5 cp = ~cp;

    my_countdown_timer_if bus_a ();
    my_countdown_timer_if bus_b ();

    assign bus_a.tick = tick;   assign bus_b.tick = tick;
    assign bus_a.ld = ld;       assign bus_b.ld = ld;
    assign bus_a.start = start; assign bus_b.start = start;
    assign bus_a.pause = pause; assign bus_b.pause = pause;
    assign bus_a.d_min = d_min; assign bus_b.d_min = d_min;
    assign bus_a.d_sec = d_sec; assign bus_b.d_sec = d_sec;

    assign o_min[0] = bus_a.q_min;  assign o_min[1] = bus_b.q_min;
    assign o_sec[0] = bus_a.q_sec;  assign o_sec[1] = bus_b.q_sec;
    assign o_run[0] = bus_a.run;    assign o_run[1] = bus_b.run;
    assign o_done[0] = bus_a.done;  assign o_done[1] = bus_b.done;
    assign o_alm[0] = bus_a.alm;    assign o_alm[1] = bus_b.alm;
    assign o_zero[0] = bus_a.zero;  assign o_zero[1] = bus_b.zero;

    my_countdown_timer #(.MAX_MIN(99), .ALARM_TICKS(AlarmTicks)) dut_a (
        .cp(cp), .cr(cr), .bus(bus_a.slave)
    );
    my_countdown_timer #(.MAX_MIN(30), .ALARM_TICKS(AlarmTicks)) dut_b (
        .cp(cp), .cr(cr), .bus(bus_b.slave)
    );

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic int load_secs(input logic [7:0] dm, input logic [7:0] ds, input int mx);
        int mt, mu, st, su, m;
        mt = int'(dm[7:4]); mu = int'(dm[3:0]);
        st = int'(ds[7:4]); su = int'(ds[3:0]);
        if (mt > 9) mt = 9;
        if (mu > 9) mu = 9;
        if (st > 5) st = 5;
        if (su > 9) su = 9;
        m = mt * 10 + mu;
        if (m > mx) m = mx;
        return m * 60 + st * 10 + su;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!cr) begin
                total[i] = 0; mode[i] = MIdle; m_alm[i] = 1'b0; alm_left[i] = 0;
            end else if (!ld) begin
                total[i] = load_secs(d_min, d_sec, max_min[i]);
                mode[i] = MIdle; m_alm[i] = 1'b0; alm_left[i] = 0;
            end else if (mode[i] == MIdle) begin
                if (start && !pause && total[i] != 0) mode[i] = MRun;
            end else if (mode[i] == MRun) begin
                if (pause) begin
                    mode[i] = MPause;
                end else if (tick && total[i] > 0) begin
                    total[i] = total[i] - 1;
                    if (total[i] == 0) begin
                        mode[i] = MDone; m_alm[i] = 1'b1; alm_left[i] = AlarmTicks;
                    end
                end
            end else if (mode[i] == MPause) begin
                if (start && !pause) mode[i] = MRun;
            end else begin
                if (tick && alm_left[i] > 0) begin
                    alm_left[i] = alm_left[i] - 1;
                    if (alm_left[i] == 0) m_alm[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            check8($sformatf("%s[%0d].q_min", tag, i), o_min[i], bcd(total[i] / 60));
            check8($sformatf("%s[%0d].q_sec", tag, i), o_sec[i], bcd(total[i] % 60));
            check1($sformatf("%s[%0d].run", tag, i), o_run[i], mode[i] == MRun);
            check1($sformatf("%s[%0d].done", tag, i), o_done[i], mode[i] == MDone);
            check1($sformatf("%s[%0d].alm", tag, i), o_alm[i], m_alm[i]);
            check1($sformatf("%s[%0d].zero", tag, i), o_zero[i], total[i] == 0);
        end
    endtask

    // One clock edge: DUT and model consume the same inputs, then pulses are released.
    task automatic clk_step(input string tag);
        @(posedge cp);
        model_edge();
        #1;
        check_all(tag);
        cr = 1'b1; ld = 1'b1; start = 1'b0; pause = 1'b0; tick = 1'b0;
    endtask

    task automatic load(input logic [7:0] m, input logic [7:0] s, input string tag);
        d_min = m; d_sec = s; ld = 1'b0;
        clk_step(tag);
    endtask

    initial begin
        cr = 1'b0; ld = 1'b1; start = 1'b0; pause = 1'b0; tick = 1'b0;
        d_min = 8'h00; d_sec = 8'h00;
        clk_step("reset");
        check8("reset_min", o_min[0], 8'h00);
        check1("reset_run", o_run[0], 1'b0);

        // Reset in the middle of a run.
        load(8'h05, 8'h30, "ld_0530");
        start = 1'b1; clk_step("start_0530");
        for (int k = 0; k < 3; k++) begin tick = 1'b1; clk_step("run_0530"); end
        check8("mid_run_min", o_min[0], 8'h05);
        check8("mid_run_sec", o_sec[0], 8'h27);
        cr = 1'b0; clk_step("rst_mid_run");
        check8("rst_mid_sec", o_sec[0], 8'h00);
        check1("rst_mid_run", o_run[0], 1'b0);

        // Borrow through every digit.
        load(8'h10, 8'h00, "ld_1000");
        start = 1'b1; clk_step("start_1000");
        tick = 1'b1; clk_step("borrow_1000");
        check8("borrow_1000_min", o_min[0], 8'h09);
        check8("borrow_1000_sec", o_sec[0], 8'h59);
        load(8'h01, 8'h00, "ld_0100");
        start = 1'b1; clk_step("start_0100");
        tick = 1'b1; clk_step("borrow_0100");
        check8("borrow_0100_sec", o_sec[0], 8'h59);

        // Expiry, alarm duration, and DONE ignoring START/PAUSE.
        load(8'h00, 8'h02, "ld_0002");
        start = 1'b1; clk_step("start_0002");
        tick = 1'b1; clk_step("expire_1");
        tick = 1'b1; clk_step("expire_0");
        check1("expire_done", o_done[0], 1'b1);
        check1("expire_alm", o_alm[0], 1'b1);
        for (int k = 0; k < AlarmTicks; k++) begin
            tick = 1'b1; clk_step("alarm_tick");
            if (k == AlarmTicks - 2) check1("alm_before_last", o_alm[0], 1'b1);
        end
        check1("alm_dropped", o_alm[0], 1'b0);
        check1("done_after_alm", o_done[0], 1'b1);
        start = 1'b1; clk_step("done_start");
        pause = 1'b1; clk_step("done_pause");
        check1("done_sticky", o_done[0], 1'b1);

        // PAUSE+START clash and TICK coinciding with transitions.
        load(8'h00, 8'h42, "ld_0042");
        start = 1'b1; clk_step("start_0042");
        for (int k = 0; k < 2; k++) begin tick = 1'b1; clk_step("run_0042"); end
        pause = 1'b1; start = 1'b1; tick = 1'b1; clk_step("clash");
        check1("clash_run", o_run[0], 1'b0);
        check8("clash_sec", o_sec[0], 8'h40);
        for (int k = 0; k < 5; k++) begin tick = 1'b1; clk_step("paused"); end
        check8("paused_sec", o_sec[0], 8'h40);
        start = 1'b1; tick = 1'b1; clk_step("resume");
        check1("resume_run", o_run[0], 1'b1);
        check8("resume_sec", o_sec[0], 8'h40);
        tick = 1'b1; clk_step("resumed_tick");

        // Clamping, including the reduced MAX_MIN instance.
        load(8'h7F, 8'hAB, "clamp_7fab");
        check8("clamp_a_min", o_min[0], 8'h79);
        check8("clamp_a_sec", o_sec[0], 8'h59);
        check8("clamp_b_min", o_min[1], 8'h30);
        load(8'h45, 8'h00, "clamp_45");
        check8("clamp_b_45", o_min[1], 8'h30);
        check8("clamp_a_45", o_min[0], 8'h45);

        // Zero start, then LD winning over a same-cycle TICK while running.
        load(8'h00, 8'h00, "ld_0000");
        start = 1'b1; clk_step("start_zero");
        check1("zero_start_run", o_run[0], 1'b0);
        check1("zero_flag", o_zero[0], 1'b1);
        load(8'h00, 8'h05, "ld_0005");
        start = 1'b1; clk_step("start_0005");
        d_min = 8'h00; d_sec = 8'h03; ld = 1'b0; tick = 1'b1; clk_step("ld_tick");
        check8("ld_tick_sec", o_sec[0], 8'h03);

        // Random traffic, biased toward short loads so runs reach DONE.
        for (int n = 0; n < 4000; n++) begin
            cr    = ($urandom_range(0, 255) != 0);
            ld    = ($urandom_range(0, 63) != 0);
            d_min = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom_range(0, 1))};
            d_sec = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom_range(0, 9))};
            start = ($urandom_range(0, 7) == 0);
            pause = ($urandom_range(0, 15) == 0);
            tick  = ($urandom_range(0, 2) == 0);
            clk_step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
